sv32_page_walker: RTL

//  Responder end of the page-walk interface: serves PageWalk_Req from the fetch and load/store TLBs and returns PageWalk_Res.

---
 rtl/sv32_page_walker_pkg.sv | 53 +++++
 rtl/pw_rq_arbiter.sv | 24 ++
 rtl/sv32_page_walker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sv32_page_walker_pkg.sv
// Shared types and constants for the Sv32 page-table walker and its requestors.
package sv32_page_walker_pkg;

    // Requestor count and the width of the requestor index carried in responses.
    localparam int PW_NUM_RQ  = 2;
    localparam int PW_RQ_ID_W = 1;

    // Sv32 PTE bit positions.
    localparam int PTE_V      = 0;
    localparam int PTE_R      = 1;
    localparam int PTE_W      = 2;
    localparam int PTE_X      = 3;
    localparam int PTE_U      = 4;
    localparam int PTE_A      = 6;
    localparam int PTE_PPN_LO = 10;
    localparam int PTE_PPN_HI = 29;

    // Walk request from one TLB miss handler.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [19:0] root_ppn;
    } page_walk_req_t;

    // Walk result, snooped by every TLB.
    typedef struct packed {
        logic                  busy;
        logic [PW_RQ_ID_W-1:0] rq_id;
        logic                  valid;
        logic [19:0]           vpn;
        logic [19:0]           ppn;
        logic [2:0]            rwx;
        logic                  user;
        logic                  is_super;
        logic                  page_fault;
    } page_walk_res_t;

    // Sv32 PTE layout; only the low 20 PPN bits address this memory.
    typedef struct packed {
        logic [1:0]  ppn_ext;
        logic [19:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv32_pte_t;

endpackage

// File: rtl/pw_rq_arbiter.sv
// Fixed-priority pick among walk requestors: lowest valid index wins.
module pw_rq_arbiter #(
    parameter int NUM_RQ = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_RQ-1:0] valid_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan from the highest index down so the lowest valid index is the last write.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        idx_o = '0;
        any_o = 1'b0;
        for (int i = NUM_RQ - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sv32_page_walker.sv
// Sv32 two-level page-table walker serving the ITLB/DTLB miss handlers.
// One walk at a time, one PTE read outstanding; a flushed walk drains its read.
module sv32_page_walker
    import sv32_page_walker_pkg::*;
#(
    parameter int NUM_RQ = PW_NUM_RQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  page_walk_req_t [NUM_RQ-1:0]   IN_rqs,
    output page_walk_res_t                OUT_res,
    input  logic                          IN_flush,
    output logic                          OUT_memRdValid,
    output logic [31:0]                   OUT_memRdAddr,
    input  logic                          IN_memRdReady,
    input  logic                          IN_memRdDValid,
    input  logic [31:0]                   IN_memRdData
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L1_REQ  = 3'd1;
    localparam logic [2:0] S_L1_WAIT = 3'd2;
    localparam logic [2:0] S_L0_REQ  = 3'd3;
    localparam logic [2:0] S_L0_WAIT = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [19:0]           vpn_q, vpn_d;
    logic [19:0]           root_ppn_q, root_ppn_d;
    logic [PW_RQ_ID_W-1:0] rq_id_q, rq_id_d;
    // Holds the next-level table PPN after L1, then the leaf PPN.
    logic [19:0]           ppn_q, ppn_d;
    logic [2:0]            rwx_q, rwx_d;
    logic                  user_q, user_d;
    logic                  is_super_q, is_super_d;
    logic                  fault_q, fault_d;
    logic                  drain_q, drain_d;

    logic [NUM_RQ-1:0]     rq_valid;
    logic [PW_RQ_ID_W-1:0] arb_idx;
    logic                  arb_any;
    page_walk_req_t        sel_req;

    logic [19:0]           pte_ppn;
    logic                  pte_v, pte_r, pte_w, pte_x, pte_u, pte_a;
    logic                  pte_bad, pte_leaf, at_l1;
    logic                  unused_bits;

    // Gather requestor valids and select the winning request.
    always_comb begin
        rq_valid = '0;
        for (int i = 0; i < NUM_RQ; i++) begin
            rq_valid[i] = IN_rqs[i].valid;
        end
        sel_req = IN_rqs[arb_idx];
    end

    pw_rq_arbiter #(
        .NUM_RQ (NUM_RQ),
        .IDX_W  (PW_RQ_ID_W)
    ) u_arb (
        .valid_i (rq_valid),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Decode the returning PTE word.
    always_comb begin
        pte_ppn  = IN_memRdData[PTE_PPN_HI:PTE_PPN_LO];
        pte_v    = IN_memRdData[PTE_V];
        pte_r    = IN_memRdData[PTE_R];
        pte_w    = IN_memRdData[PTE_W];
        pte_x    = IN_memRdData[PTE_X];
        pte_u    = IN_memRdData[PTE_U];
        pte_a    = IN_memRdData[PTE_A];
        pte_bad  = !pte_v || (pte_w && !pte_r);
        pte_leaf = pte_r || pte_x;
        at_l1    = (state_q == S_L1_WAIT);
        // PTE bits beyond the 32-bit physical space, RSW/D/G, and the page offset are not needed.
        unused_bits = ^{IN_memRdData[31:30], IN_memRdData[9:7], IN_memRdData[5],
                        sel_req.addr[11:0]};
    end

    // Walk state machine and result capture.
    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        root_ppn_d = root_ppn_q;
        rq_id_d    = rq_id_q;
        ppn_d      = ppn_q;
        rwx_d      = rwx_q;
        user_d     = user_q;
        is_super_d = is_super_q;
        fault_d    = fault_q;
        drain_d    = drain_q;

        case (state_q)
            S_IDLE: begin
                if (arb_any && !IN_flush) begin
                    state_d    = S_L1_REQ;
                    vpn_d      = sel_req.addr[31:12];
                    root_ppn_d = sel_req.root_ppn;
                    rq_id_d    = arb_idx;
                    fault_d    = 1'b0;
                    is_super_d = 1'b0;
                    drain_d    = 1'b0;
                end
            end

            S_L1_REQ, S_L0_REQ: begin
                if (IN_memRdReady) begin
                    // A read accepted together with a flush must still be drained.
                    state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    drain_d = IN_flush;
                end else if (IN_flush) begin
                    state_d = S_IDLE;
                end
            end

            S_L1_WAIT, S_L0_WAIT: begin
                if (IN_memRdDValid) begin
                    if (drain_q || IN_flush) begin
                        state_d = S_IDLE;
                        drain_d = 1'b0;
                    end else begin
                        ppn_d  = pte_ppn;
                        rwx_d  = {pte_x, pte_w, pte_r};
                        user_d = pte_u;
                        if (pte_bad) begin
                            fault_d = 1'b1;
                            state_d = S_RESP;
                        end else if (pte_leaf) begin
                            // A level-1 leaf maps a 4 MiB page and must be 4 MiB aligned.
                            is_super_d = at_l1;
                            fault_d    = !pte_a || (at_l1 && (pte_ppn[9:0] != 10'd0));
                            state_d    = S_RESP;
                        end else if (at_l1) begin
                            state_d = S_L0_REQ;
                        end else begin
                            fault_d = 1'b1;
                            state_d = S_RESP;
                        end
                    end
                end else if (IN_flush) begin
                    drain_d = 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q    <= S_IDLE;
            vpn_q      <= '0;
            root_ppn_q <= '0;
            rq_id_q    <= '0;
            ppn_q      <= '0;
            rwx_q      <= '0;
            user_q     <= 1'b0;
            is_super_q <= 1'b0;
            fault_q    <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            root_ppn_q <= root_ppn_d;
            rq_id_q    <= rq_id_d;
            ppn_q      <= ppn_d;
            rwx_q      <= rwx_d;
            user_q     <= user_d;
            is_super_q <= is_super_d;
            fault_q    <= fault_d;
            drain_q    <= drain_d;
        end
    end

    // Drive the response and the PTE read port from registered state.
    always_comb begin
        OUT_res.busy       = (state_q != S_IDLE);
        OUT_res.rq_id      = rq_id_q;
        OUT_res.valid      = (state_q == S_RESP);
        OUT_res.vpn        = vpn_q;
        OUT_res.ppn        = ppn_q;
        OUT_res.rwx        = rwx_q;
        OUT_res.user       = user_q;
        OUT_res.is_super   = is_super_q;
        OUT_res.page_fault = fault_q;

        OUT_memRdValid = (state_q == S_L1_REQ) || (state_q == S_L0_REQ);
        OUT_memRdAddr  = (state_q == S_L0_REQ) ? {ppn_q, vpn_q[9:0], 2'b00}
                                               : {root_ppn_q, vpn_q[19:10], 2'b00};
    end

endmodule
